// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle RV32I control unit. A single FSM steps each instruction through
// fetch, decode, execute, memory and writeback, and drives the datapath mux
// selects, write enables and ALU operation. Memory states wait on memready and
// can time out. Illegal encodings and memory timeouts can park the unit in TRAP.
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter bit          TRAP_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       memready,
    output logic [2:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [3:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       memreq,
    output logic       trap
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // The wait counter only has to reach WAIT_LIMIT-1; a zero limit keeps a 1-bit counter idle.
    localparam int unsigned   CW        = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam int unsigned   LIMIT_M1  = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;
    localparam logic [CW-1:0] LIMIT_CNT = LIMIT_M1[CW-1:0];

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        JAL,
        JALR,
        JLINK,
        LUI,
        BRANCH,
        TRAP
    } state_t;

    // State-decoded control fields. Enables that depend on memready or the
    // ALU flags are stored as qualifiers and combined with the live inputs.
    typedef struct packed {
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       adrSrc;
        logic       fetchEn;
        logic       pcWriteUncond;
        logic       branchEn;
        logic       regWrite;
        logic       memWrite;
        logic       memReq;
        logic       trap;
        logic       aluDecode;
        logic       aluSub;
    } ctrl_t;

    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memReq    = 1'b1;
                c.aluSrcB   = 2'b10;
                c.resultSrc = 2'b10;
                c.fetchEn   = 1'b1;
            end
            DECODE: begin
                c.aluSrcA = 2'b01;
                c.aluSrcB = 2'b01;
            end
            MEMADR: begin
                c.aluSrcA = 2'b10;
                c.aluSrcB = 2'b01;
            end
            MEMREAD: begin
                c.memReq = 1'b1;
                c.adrSrc = 1'b1;
            end
            MEMWB: begin
                c.resultSrc = 2'b01;
                c.regWrite  = 1'b1;
            end
            MEMWRITE: begin
                c.memReq   = 1'b1;
                c.memWrite = 1'b1;
                c.adrSrc   = 1'b1;
            end
            EXECR: begin
                c.aluSrcA   = 2'b10;
                c.aluSrcB   = 2'b00;
                c.aluDecode = 1'b1;
            end
            EXECI: begin
                c.aluSrcA   = 2'b10;
                c.aluSrcB   = 2'b01;
                c.aluDecode = 1'b1;
            end
            ALUWB: begin
                c.regWrite = 1'b1;
            end
            JAL: begin
                c.aluSrcA       = 2'b01;
                c.aluSrcB       = 2'b10;
                c.pcWriteUncond = 1'b1;
            end
            JALR: begin
                c.aluSrcA       = 2'b10;
                c.aluSrcB       = 2'b01;
                c.resultSrc     = 2'b10;
                c.pcWriteUncond = 1'b1;
            end
            JLINK: begin
                c.aluSrcA = 2'b01;
                c.aluSrcB = 2'b10;
            end
            LUI: begin
                c.aluSrcA = 2'b11;
                c.aluSrcB = 2'b01;
            end
            BRANCH: begin
                c.aluSrcA  = 2'b10;
                c.aluSrcB  = 2'b00;
                c.aluSub   = 1'b1;
                c.branchEn = 1'b1;
            end
            TRAP: begin
                c.trap = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    state_t        r_state;
    state_t        w_next;
    state_t        w_decodeNext;
    ctrl_t         r_ctrl;
    logic [CW-1:0] r_waitCnt;
    logic          w_illegal;
    logic          w_timeout;
    logic          w_inMem;
    logic          w_enterMem;
    logic          w_taken;
    logic [3:0]    w_aluOp;

    // Classify the opcode into its execute state and flag encodings we refuse to run.
    always_comb begin
        w_decodeNext = FETCH;
        w_illegal    = 1'b0;
        case (op)
            OP_LOAD: begin
                w_decodeNext = MEMADR;
                w_illegal    = (funct3 != 3'b010);
            end
            OP_STORE: begin
                w_decodeNext = MEMADR;
                w_illegal    = (funct3 != 3'b010);
            end
            OP_R:      w_decodeNext = EXECR;
            OP_I:      w_decodeNext = EXECI;
            OP_JAL:    w_decodeNext = JAL;
            OP_JALR: begin
                w_decodeNext = JALR;
                w_illegal    = (funct3 != 3'b000);
            end
            OP_LUI:    w_decodeNext = LUI;
            OP_AUIPC:  w_decodeNext = ALUWB;
            OP_BRANCH: begin
                w_decodeNext = BRANCH;
                w_illegal    = (funct3[2:1] == 2'b01);
            end
            default:   w_illegal = 1'b1;
        endcase
    end

    // A memory state gives up when its last allowed cycle is also not ready.
    always_comb begin
        w_inMem    = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
        w_timeout  = (WAIT_LIMIT != 0) && !memready && (r_waitCnt == LIMIT_CNT);
        w_enterMem = ((w_next == FETCH) || (w_next == MEMREAD) || (w_next == MEMWRITE))
                     && (w_next != r_state);
    end

    // Next-state selection for every state; memready wins over a timeout in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (memready)       w_next = DECODE;
                else if (w_timeout) w_next = TRAP;
            end
            DECODE: begin
                if (w_illegal) w_next = TRAP_EN ? TRAP : FETCH;
                else           w_next = w_decodeNext;
            end
            MEMADR:   w_next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (memready)       w_next = MEMWB;
                else if (w_timeout) w_next = TRAP;
            end
            MEMWB:    w_next = FETCH;
            MEMWRITE: begin
                if (memready)       w_next = FETCH;
                else if (w_timeout) w_next = TRAP;
            end
            EXECR:    w_next = ALUWB;
            EXECI:    w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            JAL:      w_next = ALUWB;
            JALR:     w_next = JLINK;
            JLINK:    w_next = ALUWB;
            LUI:      w_next = ALUWB;
            BRANCH:   w_next = FETCH;
            TRAP:     w_next = TRAP;
            default:  w_next = FETCH;
        endcase
    end

    // State register with the control word for the upcoming state registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= decodeState(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decodeState(w_next);
        end
    end

    // Consecutive not-ready cycles in the current memory state, restarted on each entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= '0;
        end else if (w_enterMem) begin
            r_waitCnt <= '0;
        end else if (w_inMem && !memready && (WAIT_LIMIT != 0)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // Branch condition from funct3 and the ALU compare flags.
    always_comb begin
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // ALU operation for R/I execution; sub only exists for register-register ops.
    always_comb begin
        case (funct3)
            3'b000:  w_aluOp = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_aluOp = ALU_SLL;
            3'b010:  w_aluOp = ALU_SLT;
            3'b011:  w_aluOp = ALU_SLTU;
            3'b100:  w_aluOp = ALU_XOR;
            3'b101:  w_aluOp = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_aluOp = ALU_OR;
            default: w_aluOp = ALU_AND;
        endcase
    end

    // Final ALU select: decoded op in execute, subtract for branch compare, add otherwise.
    always_comb begin
        if (r_ctrl.aluDecode)   alucontrol = w_aluOp;
        else if (r_ctrl.aluSub) alucontrol = ALU_SUB;
        else                    alucontrol = ALU_ADD;
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_STORE:  immsrc = 3'b001;
            OP_BRANCH: immsrc = 3'b010;
            OP_JAL:    immsrc = 3'b011;
            OP_LUI:    immsrc = 3'b100;
            OP_AUIPC:  immsrc = 3'b100;
            default:   immsrc = 3'b000;
        endcase
    end

    assign alusrca   = r_ctrl.aluSrcA;
    assign alusrcb   = r_ctrl.aluSrcB;
    assign resultsrc = r_ctrl.resultSrc;
    assign adrsrc    = r_ctrl.adrSrc;
    assign memreq    = r_ctrl.memReq;
    assign trap      = r_ctrl.trap;

    // Architectural writes are suppressed for the whole reset cycle.
    assign irwrite  = r_ctrl.fetchEn & memready & ~reset;
    assign pcwrite  = ((r_ctrl.fetchEn & memready) | r_ctrl.pcWriteUncond
                       | (r_ctrl.branchEn & w_taken)) & ~reset;
    assign regwrite = r_ctrl.regWrite & ~reset;
    assign memwrite = r_ctrl.memWrite & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Drives instructions into two control units (trapping and non-trapping) and
// checks every cycle's control word against a per-instruction cycle recipe.
module tb_multicycle_ctrl;

    localparam int LIMIT = 15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [2:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic [3:0] alucontrol;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic       memwrite;
        logic       memreq;
        logic       trap;
    } ctl_t;

    typedef struct {
        ctl_t exp1;
        ctl_t exp0;
        ctl_t mask;
        int   ins;
        int   cyc;
    } sb_t;

    typedef enum int {C_ILL, C_LW, C_SW, C_R, C_I, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BR} cls_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       memready = 1'b0;

    logic [2:0] immsrc1, immsrc0;
    logic [1:0] alusrca1, alusrca0, alusrcb1, alusrcb0, resultsrc1, resultsrc0;
    logic       adrsrc1, adrsrc0;
    logic [3:0] alucontrol1, alucontrol0;
    logic       irwrite1, irwrite0, pcwrite1, pcwrite0, regwrite1, regwrite0;
    logic       memwrite1, memwrite0, memreq1, memreq0, trap1, trap0;

    sb_t sbq[$];
    int  nVec = 0;
    int  nMis = 0;
    int  insIdx = 0;
    int  cycIdx = 0;

    multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .TRAP_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .memready(memready),
        .immsrc(immsrc1), .alusrca(alusrca1), .alusrcb(alusrcb1), .resultsrc(resultsrc1),
        .adrsrc(adrsrc1), .alucontrol(alucontrol1), .irwrite(irwrite1), .pcwrite(pcwrite1),
        .regwrite(regwrite1), .memwrite(memwrite1), .memreq(memreq1), .trap(trap1)
    );

    multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .TRAP_EN(1'b0)) dutNoTrap (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .memready(memready),
        .immsrc(immsrc0), .alusrca(alusrca0), .alusrcb(alusrcb0), .resultsrc(resultsrc0),
        .adrsrc(adrsrc0), .alucontrol(alucontrol0), .irwrite(irwrite0), .pcwrite(pcwrite0),
        .regwrite(regwrite0), .memwrite(memwrite0), .memreq(memreq0), .trap(trap0)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    function automatic ctl_t sample1();
        ctl_t c;
        c = {immsrc1, alusrca1, alusrcb1, resultsrc1, adrsrc1, alucontrol1,
             irwrite1, pcwrite1, regwrite1, memwrite1, memreq1, trap1};
        return c;
    endfunction

    function automatic ctl_t sample0();
        ctl_t c;
        c = {immsrc0, alusrca0, alusrcb0, resultsrc0, adrsrc0, alucontrol0,
             irwrite0, pcwrite0, regwrite0, memwrite0, memreq0, trap0};
        return c;
    endfunction

    // Reference rules: immediate format, ALU op, branch condition, instruction class
    function automatic logic [2:0] immOf(input logic [6:0] o);
        if (o == OP_STORE) return 3'd1;
        if (o == OP_BRANCH) return 3'd2;
        if (o == OP_JAL) return 3'd3;
        if (o == OP_LUI || o == OP_AUIPC) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] aluOf(input logic [2:0] f3, input logic f7, input bit isR);
        logic [3:0] table8 [8];
        table8 = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'd0 && isR && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd9;
        return table8[f3];
    endfunction

    function automatic logic takenOf(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        logic cond;
        case (f3[2:1])
            2'b00:   cond = z;
            2'b10:   cond = l;
            2'b11:   cond = lu;
            default: return 1'b0;
        endcase
        return f3[0] ? !cond : cond;
    endfunction

    function automatic cls_t classify(input logic [6:0] o, input logic [2:0] f3);
        if (o == OP_LOAD)   return (f3 == 3'd2) ? C_LW : C_ILL;
        if (o == OP_STORE)  return (f3 == 3'd2) ? C_SW : C_ILL;
        if (o == OP_R)      return C_R;
        if (o == OP_I)      return C_I;
        if (o == OP_JAL)    return C_JAL;
        if (o == OP_JALR)   return (f3 == 3'd0) ? C_JALR : C_ILL;
        if (o == OP_LUI)    return C_LUI;
        if (o == OP_AUIPC)  return C_AUIPC;
        if (o == OP_BRANCH) return (f3 == 3'd2 || f3 == 3'd3) ? C_ILL : C_BR;
        return C_ILL;
    endfunction

    function automatic bit knownOp(input logic [6:0] o);
        return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_R) || (o == OP_I) || (o == OP_JAL)
            || (o == OP_JALR) || (o == OP_LUI) || (o == OP_AUIPC) || (o == OP_BRANCH);
    endfunction

    function automatic ctl_t baseWord();
        ctl_t c;
        c = '0;
        c.immsrc = immOf(op);
        return c;
    endfunction

    function automatic ctl_t fetchWord();
        ctl_t c;
        c = baseWord();
        c.memreq    = 1'b1;
        c.alusrcb   = 2'd2;
        c.resultsrc = 2'd2;
        return c;
    endfunction

    task automatic noise();
        zero     = 1'($urandom);
        lt       = 1'($urandom);
        ltu      = 1'($urandom);
        memready = 1'($urandom);
    endtask

    // Push the expected words for the current cycle, then advance one clock
    task automatic tick(input ctl_t e1, input ctl_t e0, input ctl_t m);
        sb_t s;
        s.exp1 = e1;
        s.exp0 = e0;
        s.mask = m;
        s.ins  = insIdx;
        s.cyc  = cycIdx;
        sbq.push_back(s);
        cycIdx++;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        ctl_t en;
        en = '0;
        en.irwrite  = 1'b1;
        en.pcwrite  = 1'b1;
        en.regwrite = 1'b1;
        en.memwrite = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise();
            tick('0, '0, en);
        end
        reset = 1'b0;
    endtask

    // Memory access: waits not-ready cycles then one ready cycle, unless the limit trips first
    task automatic memPhase(input ctl_t w, input int waits, input bit isFetch, output bit timedOut);
        ctl_t e;
        timedOut = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            e = w;
            zero = 1'($urandom);
            lt   = 1'($urandom);
            ltu  = 1'($urandom);
            memready = (k == waits);
            if (memready && isFetch) begin
                e.irwrite = 1'b1;
                e.pcwrite = 1'b1;
            end
            tick(e, e, '1);
            if (!memready && k == LIMIT - 1) begin
                timedOut = 1'b1;
                break;
            end
        end
    endtask

    // Trapping unit sits in TRAP; the other one is either trapped too or waiting in fetch
    task automatic trapHold(input int n, input bit otherInFetch);
        ctl_t t;
        ctl_t e0;
        t = baseWord();
        t.trap = 1'b1;
        for (int i = 0; i < n; i++) begin
            zero = 1'($urandom);
            lt   = 1'($urandom);
            ltu  = 1'($urandom);
            memready = 1'b0;
            e0 = (otherInFetch && i < LIMIT) ? fetchWord() : t;
            tick(t, e0, '1);
        end
    endtask

    // One instruction from fetch to retirement. abortMode 1 resets after decode,
    // 2 resets in the first cycle of the data memory access.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input int fw, input int mw, input int flagSel,
                                 input int abortMode, input int hold);
        ctl_t w;
        bit   to;
        cls_t c;
        insIdx++;
        cycIdx = 0;
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        c = classify(o, f3);

        memPhase(fetchWord(), fw, 1'b1, to);
        if (to) begin
            trapHold(4, 1'b0);
            doReset(1);
            return;
        end

        w = baseWord();
        w.alusrca = 2'd1;
        w.alusrcb = 2'd1;
        noise();
        tick(w, w, '1);
        if (abortMode == 1) begin
            doReset(1);
            return;
        end
        if (c == C_ILL) begin
            trapHold(hold, 1'b1);
            doReset(1);
            return;
        end

        w = baseWord();
        case (c)
            C_LW, C_SW: begin
                w.alusrca = 2'd2;
                w.alusrcb = 2'd1;
                noise();
                tick(w, w, '1);
                if (abortMode == 2) begin
                    doReset(1);
                    return;
                end
                w = baseWord();
                w.memreq = 1'b1;
                w.adrsrc = 1'b1;
                w.memwrite = (c == C_SW);
                memPhase(w, mw, 1'b0, to);
                if (to) begin
                    trapHold(3, 1'b0);
                    doReset(1);
                    return;
                end
                if (c == C_LW) begin
                    w = baseWord();
                    w.resultsrc = 2'd1;
                    w.regwrite  = 1'b1;
                    noise();
                    tick(w, w, '1);
                end
                return;
            end
            C_R, C_I: begin
                w.alusrca = 2'd2;
                w.alusrcb = (c == C_I) ? 2'd1 : 2'd0;
                w.alucontrol = aluOf(f3, f7, c == C_R);
                noise();
                tick(w, w, '1);
            end
            C_JAL: begin
                w.alusrca = 2'd1;
                w.alusrcb = 2'd2;
                w.pcwrite = 1'b1;
                noise();
                tick(w, w, '1);
            end
            C_JALR: begin
                w.alusrca = 2'd2;
                w.alusrcb = 2'd1;
                w.resultsrc = 2'd2;
                w.pcwrite = 1'b1;
                noise();
                tick(w, w, '1);
                w = baseWord();
                w.alusrca = 2'd1;
                w.alusrcb = 2'd2;
                noise();
                tick(w, w, '1);
            end
            C_LUI: begin
                w.alusrca = 2'd3;
                w.alusrcb = 2'd1;
                noise();
                tick(w, w, '1);
            end
            C_BR: begin
                noise();
                if (flagSel >= 0) begin
                    zero = flagSel[2];
                    lt   = flagSel[1];
                    ltu  = flagSel[0];
                end
                w.alusrca = 2'd2;
                w.alucontrol = 4'd1;
                w.pcwrite = takenOf(f3, zero, lt, ltu);
                tick(w, w, '1);
                return;
            end
            default: begin
            end
        endcase

        // common register writeback for ALU, jump, lui and auipc
        w = baseWord();
        w.regwrite = 1'b1;
        noise();
        tick(w, w, '1);
    endtask

    task automatic checkOutput(input string tag, input ctl_t act, input ctl_t exp,
                               input ctl_t msk, input int ins, input int cyc);
        logic [$bits(ctl_t)-1:0] a;
        logic [$bits(ctl_t)-1:0] x;
        a = act & msk;
        x = exp & msk;
        nVec++;
        if (a !== x) begin
            nMis++;
            $display("[TB] FAIL %s ins=%0d cyc=%0d got=%h want=%h", tag, ins, cyc, a, x);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("trapen", sample1(), e.exp1, e.mask, e.ins, e.cyc);
                checkOutput("notrap", sample0(), e.exp0, e.mask, e.ins, e.cyc);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [6:0] o;
        logic [2:0] f3;
        cls_t       pick;
        int         abortMode;

        @(posedge clk);
        #1;
        doReset(2);

        // directed
        applyStimulus(OP_LOAD,   3'd2, 1'b0, 0, 0, -1, 0, 0);
        applyStimulus(OP_STORE,  3'd2, 1'b0, 0, 3, -1, 0, 0);
        applyStimulus(OP_BRANCH, 3'd1, 1'b0, 0, 0, 3'b000, 0, 0);
        applyStimulus(OP_BRANCH, 3'd1, 1'b0, 0, 0, 3'b100, 0, 0);
        applyStimulus(OP_BRANCH, 3'd7, 1'b0, 0, 0, 3'b001, 0, 0);
        applyStimulus(OP_R,      3'd0, 1'b1, 0, 0, -1, 0, 0);
        applyStimulus(OP_I,      3'd0, 1'b1, 0, 0, -1, 0, 0);
        applyStimulus(7'b1111111, 3'd0, 1'b0, 0, 0, -1, 0, 20);
        applyStimulus(OP_AUIPC,  3'd0, 1'b0, LIMIT, 0, -1, 0, 0);
        applyStimulus(OP_AUIPC,  3'd0, 1'b0, LIMIT - 1, 0, -1, 0, 0);
        applyStimulus(OP_LUI,    3'd0, 1'b0, 1, 0, -1, 0, 0);
        applyStimulus(OP_JAL,    3'd0, 1'b0, 0, 0, -1, 0, 0);
        applyStimulus(OP_JALR,   3'd0, 1'b0, 2, 0, -1, 0, 0);
        applyStimulus(OP_LOAD,   3'd2, 1'b0, 0, LIMIT, -1, 0, 0);
        applyStimulus(OP_STORE,  3'd2, 1'b0, 0, 2, -1, 2, 0);
        applyStimulus(OP_JAL,    3'd0, 1'b0, 0, 0, -1, 1, 0);

        // randomized
        for (int n = 0; n < 300; n++) begin
            pick = cls_t'($urandom_range(0, 9));
            f3 = 3'($urandom);
            case (pick)
                C_LW:    begin o = OP_LOAD;  f3 = 3'd2; end
                C_SW:    begin o = OP_STORE; f3 = 3'd2; end
                C_R:     o = OP_R;
                C_I:     o = OP_I;
                C_JAL:   o = OP_JAL;
                C_JALR:  begin o = OP_JALR; f3 = 3'd0; end
                C_LUI:   o = OP_LUI;
                C_AUIPC: o = OP_AUIPC;
                C_BR: begin
                    o = OP_BRANCH;
                    if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: begin
                            o = 7'($urandom);
                            for (int t = 0; t < 8 && knownOp(o); t++) o = 7'($urandom);
                            if (knownOp(o)) o = 7'b1111111;
                        end
                        1: begin
                            o = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
                            if (f3 == 3'd2) f3 = 3'd3;
                        end
                        2: begin
                            o = OP_BRANCH;
                            f3 = {2'b01, 1'($urandom)};
                        end
                        default: begin
                            o = OP_JALR;
                            if (f3 == 3'd0) f3 = 3'd1;
                        end
                    endcase
                end
            endcase
            abortMode = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
            applyStimulus(o, f3, 1'($urandom), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 19) == 0) ? LIMIT : int'($urandom_range(0, 3)),
                          -1, abortMode, int'($urandom_range(3, 20)));
        end

        repeat (2) @(negedge clk);
        if (sbq.size() != 0) begin
            nMis++;
            $display("[TB] FAIL drain got=%0d want=0 entries left", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle RV32I control unit with memory wait-state handshake, full branch set, jalr/lui/auipc, and illegal-instruction/bus-timeout trapping. Sits between the instruction register and the multicycle datapath, driving its mux selects, enables and ALU operation. Successor to the current lw/sw/R/I/jal/beq controller; all instructions are encoded in one FSM with internal ALU and immediate decode.

## Interface
- WAIT_LIMIT, 15: consecutive not-ready cycles in a memory state before timeout; 0 disables timeout.
- TRAP_EN, 1: 1 = illegal instruction enters TRAP; 0 = illegal instruction retires as a no-op.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero, lt, ltu  in  1 each  ALU flags: result==0, signed A<B, unsigned A<B.
- memready  in  1  memory completes current request this cycle.
- immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alusrca  out  2  00 PC, 01 OldPC, 10 A(rs1), 11 zero.
- alusrcb  out  2  00 WriteData(rs2), 01 ImmExt, 10 constant 4.
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- adrsrc  out  1  0 PC, 1 Result.
- alucontrol  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- irwrite, pcwrite, regwrite, memwrite, memreq, trap  out  1 each.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, JLINK, LUI, BRANCH, TRAP.
- Defaults (any state unless listed): alusrca 00, alusrcb 00, resultsrc 00, adrsrc 0, alucontrol add, all enables 0. immsrc is combinational from op in every state.
- FETCH: memreq=1, adrsrc 0, alusrca 00, alusrcb 10, resultsrc 10. Waits for memready; irwrite=pcwrite=1 only in the memready cycle, then DECODE.
- DECODE: alusrca 01, alusrcb 01 (ALUOut <= OldPC+imm). Next: lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; jal -> JAL; jalr -> JALR; lui -> LUI; auipc -> ALUWB; branch -> BRANCH.
- Illegal in DECODE: unknown opcode; load/store funct3 != 010; branch funct3 010/011; jalr funct3 != 000. Illegal -> TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0).
- MEMADR: alusrca 10, alusrcb 01; -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: memreq, adrsrc 1; on memready -> MEMWB. MEMWB: resultsrc 01, regwrite; -> FETCH.
- MEMWRITE: memreq, memwrite, adrsrc 1 held until the memready cycle; -> FETCH.
- EXECR: alusrca 10, alusrcb 00. EXECI: alusrca 10, alusrcb 01. Both -> ALUWB. ALUWB: regwrite, resultsrc 00; -> FETCH.
- ALU decode (EXECR/EXECI) by funct3: 000 add, or sub iff op[5]&funct7b5; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, sra iff funct7b5; 110 or; 111 and.
- JAL: alusrca 01, alusrcb 10, pcwrite (PC <= ALUOut); -> ALUWB.
- JALR: alusrca 10, alusrcb 01, resultsrc 10, pcwrite; -> JLINK. JLINK: alusrca 01, alusrcb 10; -> ALUWB.
- LUI: alusrca 11, alusrcb 01; -> ALUWB.
- BRANCH: alusrca 10, alusrcb 00, alucontrol sub, resultsrc 00. pcwrite = taken: funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. -> FETCH.
- TRAP: trap=1, all enables 0, memreq 0; stays until reset.
- Timeout: counter clears on entering FETCH/MEMREAD/MEMWRITE; increments each memready=0 cycle there. After WAIT_LIMIT consecutive not-ready cycles -> TRAP (independent of TRAP_EN). memready in the limit cycle wins.

## Timing
- Reset: state FETCH, counter 0; while reset=1 irwrite, pcwrite, regwrite, memwrite forced 0. First cycle after reset: memreq=1, trap=0.
- Zero-wait latencies (cycles): lw 5, sw 4, R/I 4, auipc 3, lui 4, jal 4, jalr 5, branch 3. Each memready=0 cycle in a memory state adds 1.
- Reset mid-instruction (incl. TRAP, mid-wait): next cycle FETCH, no writes in the reset cycle.

## Test plan
- lw, memready=1 always: FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1, resultsrc=01 in cycle 5 only.
- sw with memready low 3 cycles in MEMWRITE: memwrite+memreq high 4 cycles, adrsrc=1, then FETCH.
- bne (funct3 001) zero=0 -> pcwrite=1 in BRANCH; zero=1 -> 0; bgeu ltu=1 -> 0.
- sub R-type (op 0110011, funct3 000, funct7b5 1) -> alucontrol 0001 in EXECR; addi with funct7b5=1 -> 0000.
- op 7'b1111111, TRAP_EN=1 -> TRAP, trap=1 held 20 cycles; TRAP_EN=0 -> FETCH, no writes.
- WAIT_LIMIT=15, memready=0 in FETCH: TRAP entered after 15 cycles; memready=1 on the 15th cycle -> DECODE instead.
